// File: rtl/immgen_pipe_if.sv
// Stream bundle for immgen_pipe: the upstream instruction handshake, the
// downstream immediate handshake and the pipeline flush.
interface immgen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       inst_i;
    logic [2:0]        imm_op_i;
    logic [TAG_W-1:0]  tag_i;
    logic              valid_o;
    logic              ready_i;
    logic [XLEN-1:0]   immgen_o;
    logic [TAG_W-1:0]  tag_o;

    modport master (
        output flush_i, valid_i, inst_i, imm_op_i, tag_i, ready_i,
        input  ready_o, valid_o, immgen_o, tag_o
    );

    modport slave (
        input  flush_i, valid_i, inst_i, imm_op_i, tag_i, ready_i,
        output ready_o, valid_o, immgen_o, tag_o
    );
endinterface

// File: rtl/immgen_pipe.sv
// Pipelined RISC-V immediate generator: one registered output stage plus a
// one-entry skid buffer, so ready_o is a register.
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int FLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    immgen_pipe_if.slave bus
);

    if (!(XLEN == 32 || XLEN == 64) || !(FLEN == 32 || FLEN == 64) || FLEN > XLEN) begin : g_param_check
        $error("immgen_pipe: illegal XLEN/FLEN combination");
    end

    typedef enum logic [2:0] {
        OP_I = 3'b000,
        OP_S = 3'b001,
        OP_B = 3'b010,
        OP_U = 3'b011,
        OP_J = 3'b100,
        OP_R = 3'b101,
        OP_F = 3'b110,
        OP_Z = 3'b111
    } imm_op_t;

    logic [31:0]      inst;
    imm_op_t          op;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_ext;
    logic [FLEN-1:0]  fp_val;
    logic [XLEN-1:0]  fp_box;
    logic [XLEN-1:0]  result;

    assign inst = bus.inst_i;
    assign op   = imm_op_t'(bus.imm_op_i);

    // Compressed FP immediate: rebias the 5-bit exponent, left-align the mantissa.
    if (FLEN == 32) begin : g_fp32
        assign fp_val = {inst[31], 8'(inst[30:26]) + 8'd112, inst[25:20], 17'h0};
    end else begin : g_fp64
        assign fp_val = {inst[31], 11'(inst[30:26]) + 11'd1008, inst[25:20], 46'h0};
    end

    always_comb begin
        imm32 = '0;
        unique case (op)
            OP_I:    imm32 = {{20{inst[31]}}, inst[31:20]};
            OP_S:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_B:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_U:    imm32 = {inst[31:12], 12'h000};
            OP_J:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'($signed(imm32));

        // Upper bits stay all-ones as the NaN-box when FLEN < XLEN.
        fp_box             = '1;
        fp_box[FLEN-1:0]   = fp_val;

        result = imm_ext;
        unique case (op)
            OP_R:    result = '0;
            OP_F:    result = fp_box;
            OP_Z:    result = XLEN'(inst[19:15]);
            default: result = imm_ext;
        endcase
    end

    logic              out_valid;
    logic [XLEN-1:0]   out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              skid_valid;
    logic [XLEN-1:0]   skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              ready_q;
    logic              accept;
    logic              out_free;

    assign accept   = bus.valid_i && ready_q;
    assign out_free = !out_valid || bus.ready_i;

    // ready_q always mirrors !skid_valid but is kept as its own flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            ready_q    <= 1'b1;
        end else if (bus.flush_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_imm    <= skid_imm;
                out_tag    <= skid_tag;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_imm   <= result;
                out_tag   <= bus.tag_i;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= result;
            skid_tag   <= bus.tag_i;
            ready_q    <= 1'b0;
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = out_valid;
    assign bus.immgen_o = out_imm;
    assign bus.tag_o    = out_tag;

endmodule

// File: tb/tb_immgen_pipe.sv
// Scoreboard bench for immgen_pipe: three configurations (32/32, 64/32, 64/64)
// share one input stream and are checked against an arithmetic reference model.
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, valid, rdy;
    logic [31:0] inst;
    logic [2:0]  op;
    logic [4:0]  tag;

    always #5 clk = ~clk;

    immgen_pipe_if #(.XLEN(32), .TAG_W(5)) b32  ();
    immgen_pipe_if #(.XLEN(64), .TAG_W(5)) b64s ();
    immgen_pipe_if #(.XLEN(64), .TAG_W(5)) b64d ();

    assign b32.flush_i   = flush;  assign b64s.flush_i   = flush;  assign b64d.flush_i   = flush;
    assign b32.valid_i   = valid;  assign b64s.valid_i   = valid;  assign b64d.valid_i   = valid;
    assign b32.inst_i    = inst;   assign b64s.inst_i    = inst;   assign b64d.inst_i    = inst;
    assign b32.imm_op_i  = op;     assign b64s.imm_op_i  = op;     assign b64d.imm_op_i  = op;
    assign b32.tag_i     = tag;    assign b64s.tag_i     = tag;    assign b64d.tag_i     = tag;
    assign b32.ready_i   = rdy;    assign b64s.ready_i   = rdy;    assign b64d.ready_i   = rdy;

    immgen_pipe #(.XLEN(32), .FLEN(32), .TAG_W(5)) u32  (.clk_i(clk), .rst_i(rst), .bus(b32));
    immgen_pipe #(.XLEN(64), .FLEN(32), .TAG_W(5)) u64s (.clk_i(clk), .rst_i(rst), .bus(b64s));
    immgen_pipe #(.XLEN(64), .FLEN(64), .TAG_W(5)) u64d (.clk_i(clk), .rst_i(rst), .bus(b64d));

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  op;
        logic [4:0]  tag;
    } entry_t;

    entry_t sb[$];
    int     errors = 0;
    int     checks = 0;
    logic   done   = 1'b0;

    // Immediate value from the field weights, with two's-complement wrap for the sign bit.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] o,
                                            input int xlen, input int flen);
        logic [63:0] v;
        int          mbits;
        v = 64'd0;
        case (o)
            3'd0: v = 64'(i[30:20]) - (i[31] ? 64'd2048 : 64'd0);
            3'd1: v = 64'(i[11:7]) + 64'(i[30:25]) * 64'd32 - (i[31] ? 64'd2048 : 64'd0);
            3'd2: v = 64'(i[11:8]) * 64'd2 + 64'(i[30:25]) * 64'd32 + 64'(i[7]) * 64'd2048
                      - (i[31] ? 64'd4096 : 64'd0);
            3'd3: v = 64'(i[30:12]) * 64'd4096 - (i[31] ? 64'h8000_0000 : 64'd0);
            3'd4: v = 64'(i[30:21]) * 64'd2 + 64'(i[20]) * 64'd2048 + 64'(i[19:12]) * 64'd4096
                      - (i[31] ? 64'h10_0000 : 64'd0);
            3'd5: v = 64'd0;
            3'd6: begin
                mbits = (flen == 32) ? 23 : 52;
                v = (64'(i[31]) << (flen - 1))
                  + ((64'(i[30:26]) + ((flen == 32) ? 64'd112 : 64'd1008)) << mbits)
                  + (64'(i[25:20]) << (mbits - 6));
                if (xlen > flen) v = v | ~((64'd1 << flen) - 64'd1);
            end
            default: v = 64'(i[19:15]);
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: occupancy-based valid/ready expectations, hold-stable check, in-order data.
    logic [63:0] hold32, hold64;
    logic [4:0]  hold_tag;
    logic        stalled = 1'b0;

    always @(negedge clk) begin
        entry_t e;
        if (rst || flush) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            check_output("valid_o_32",  64'(b32.valid_o),  64'(sb.size() > 0));
            check_output("valid_o_64d", 64'(b64d.valid_o), 64'(sb.size() > 0));
            check_output("ready_o_32",  64'(b32.ready_o),  64'(sb.size() < 2));
            check_output("ready_o_64s", 64'(b64s.ready_o), 64'(sb.size() < 2));
            if (stalled) begin
                check_output("hold_imm_32", 64'(b32.immgen_o), hold32);
                check_output("hold_imm_64", b64d.immgen_o,     hold64);
                check_output("hold_tag",    64'(b32.tag_o),    64'(hold_tag));
            end
            stalled  = b32.valid_o && !rdy;
            hold32   = 64'(b32.immgen_o);
            hold64   = b64d.immgen_o;
            hold_tag = b32.tag_o;
            if (b32.valid_o && rdy && sb.size() > 0) begin
                e = sb.pop_front();
                check_output("imm_32_32", 64'(b32.immgen_o), ref_imm(e.inst, e.op, 32, 32));
                check_output("imm_64_32", b64s.immgen_o,     ref_imm(e.inst, e.op, 64, 32));
                check_output("imm_64_64", b64d.immgen_o,     ref_imm(e.inst, e.op, 64, 64));
                check_output("tag_32",    64'(b32.tag_o),    64'(e.tag));
                check_output("tag_64d",   64'(b64d.tag_o),   64'(e.tag));
            end
            if (valid && b32.ready_o) sb.push_back('{inst, op, tag});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] i, input logic [2:0] o,
                                  input logic [4:0] t);
        valid = v;
        inst  = i;
        op    = o;
        tag   = t;
    endtask

    // Present one entry and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] i, input logic [2:0] o, input logic [4:0] t);
        int n = 0;
        apply_stimulus(1'b1, i, o, t);
        @(negedge clk);
        while (!b32.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("send_accept", 64'(b32.ready_o), 64'd1);
        step();
        valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; rdy = 1'b0;
        apply_stimulus(1'b0, 32'h0, 3'd0, 5'd0);
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_imm_32",  64'(b32.immgen_o), 64'd0);
        check_output("reset_imm_64d", b64d.immgen_o,     64'd0);
        check_output("reset_tag",     64'(b32.tag_o),    64'd0);
        step();

        rdy = 1'b1;
        send(32'hFFF00093, 3'd0, 5'd1);
        check_output("latency_valid", 64'(b32.valid_o),  64'd1);
        check_output("latency_imm",   64'(b32.immgen_o), 64'hFFFF_FFFF);
        send(32'h3C000000, 3'd6, 5'd2);
        send(32'h800000B7, 3'd3, 5'd3);
        send(32'h000FD073, 3'd7, 5'd4);
        send(32'h8000_0FE3, 3'd2, 5'd5);
        send(32'hFE1F_F0EF, 3'd4, 5'd6);
        repeat (3) step();

        rdy = 1'b0;
        fork
            begin
                send(32'h0010_0093, 3'd0, 5'd1);
                send(32'hFE00_0EA3, 3'd1, 5'd2);
                send(32'hBC00_0000, 3'd6, 5'd3);
                send(32'h0000_0000, 3'd5, 5'd4);
            end
            begin
                repeat (3) step();
                check_output("bp_tag_held",  64'(b32.tag_o),   64'd1);
                check_output("bp_ready_low", 64'(b32.ready_o), 64'd0);
                step();
                rdy = 1'b1;
            end
        join
        repeat (4) step();

        rdy = 1'b0;
        send(32'h1234_5678, 3'd0, 5'd5);
        send(32'h8765_4321, 3'd4, 5'd6);
        apply_stimulus(1'b1, 32'hAAAA_5555, 3'd3, 5'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check_output("flush_valid", 64'(b32.valid_o), 64'd0);
        check_output("flush_ready", 64'(b32.ready_o), 64'd1);
        step();
        rdy = 1'b1;
        repeat (3) step();

        rdy = 1'b0;
        send(32'hCAFE_F00D, 3'd1, 5'd8);
        send(32'h0F0F_0F0F, 3'd6, 5'd9);
        apply_stimulus(1'b1, 32'hFFFF_FFFF, 3'd0, 5'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check_output("rst_valid",   64'(b32.valid_o),  64'd0);
        check_output("rst_ready",   64'(b32.ready_o),  64'd1);
        check_output("rst_imm_64s", b64s.immgen_o,     64'd0);
        check_output("rst_tag",     64'(b64s.tag_o),   64'd0);
        step();
        rdy = 1'b1;
        send(32'h7FF0_0013, 3'd0, 5'd11);
        send(32'h000F_8073, 3'd7, 5'd12);
        repeat (3) step();

        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send($urandom, 3'($urandom_range(0, 7)), 5'(k));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    step();
                    rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join

        rdy = 1'b1;
        for (int n = 0; n < 50 && sb.size() > 0; n++) step();
        check_output("drain_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage of the FP-capable RISC-V core.
- Generalises the combinational immediate extractor in three ways:
  - XLEN selectable as 32 or 64.
  - FLEN selectable as 32 or 64 for the compressed FP-immediate (F-type) expansion, with NaN-boxing when FLEN < XLEN.
  - Adds a CSR zimm mode.
- Valid/ready handshake on both sides, a registered output stage and a 1-entry skid buffer, so that ready_o is a pure register output.

Parameters:
- XLEN, 32, integer/output datapath width; legal values 32 or 64.
- FLEN, 32, F-type expansion format; 32 = binary32, 64 = binary64. FLEN must be <= XLEN (elaboration error otherwise).
- TAG_W, 5, width of the sideband tag carried alongside each instruction (e.g. rd index or ROB id).

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, synchronous active-high reset.
- flush_i, input, 1, synchronous pipeline flush; drops all held entries.
- valid_i, input, 1, input entry valid.
- ready_o, output, 1, block can accept an entry this cycle.
- inst_i, input, 32, raw instruction word.
- imm_op_i, input, 3, immediate format select.
- tag_i, input, TAG_W, sideband tag.
- valid_o, output, 1, output entry valid.
- ready_i, input, 1, downstream accepts output this cycle.
- immgen_o, output, XLEN, expanded immediate.
- tag_o, output, TAG_W, tag of the output entry.

Behaviour:
- Reset: rst_i high at a clock edge clears valid_o and the skid valid, sets ready_o=1, immgen_o=0, tag_o=0. Reset takes priority over every other input.
- Flush (flush_i=1, rst_i=0): clears both valids and sets ready_o=1 next cycle. Data registers are don't-care. An input presented in the same cycle is dropped.
- Accept condition: valid_i && ready_o. Output transfer condition: valid_o && ready_i.
- ready_o = !skid_valid. It is registered and never depends combinationally on ready_i.
- Latency: an entry accepted at edge N is visible on valid_o/immgen_o after edge N (one cycle). Throughput is 1 entry per cycle while ready_i=1.
- On each edge, in priority order:
  - Output register empty, or being transferred:
    - If skid_valid: skid moves into the output register, and the input is not accepted (ready_o was 0).
    - Else, on accept: the input result is loaded into the output register.
    - Else: valid_o clears.
  - Output register full and stalled (ready_i=0): an accepted input is loaded into the skid, and ready_o drops next cycle.
- Ordering is strictly FIFO. Entries are never duplicated or lost except on flush or reset.
- Outputs hold stable while valid_o && !ready_i.
- Expansion by imm_op_i. Sign-extend = replicate inst_i[31] up to bit XLEN-1.
  - 000 I: sext(inst[31:20]).
  - 001 S: sext({inst[31:25],inst[11:7]}).
  - 010 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - 011 U: sext({inst[31:12],12'h000}). Sign-extends in RV64.
  - 100 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - 101 R: 0.
  - 110 F:
    - sign = inst[31]; 5-bit exp e = inst[30:26]; 6-bit mantissa m = inst[25:20].
    - FLEN=32: {sign, e+112 (8-bit), m, 17'h0}.
    - FLEN=64: {sign, e+1008 (11-bit), m, 46'h0}.
    - e=0 maps to the plain biased value; no subnormal, inf or NaN special-casing.
    - If XLEN>FLEN, bits XLEN-1:FLEN are all ones (NaN-box).
  - 111 Z (CSR zimm): zero-extend inst[19:15].

Test Plan:
- XLEN=32: inst 0xFFF00093, op 000, ready_i=1 -> one cycle later valid_o=1, immgen_o=0xFFFFFFFF. XLEN=64 gives 0xFFFFFFFFFFFFFFFF.
- F-type, inst 0x3C000000, op 110:
  - XLEN=32/FLEN=32 -> 0x3F800000.
  - XLEN=64/FLEN=32 -> 0xFFFFFFFF3F800000.
  - XLEN=64/FLEN=64 -> 0x3FF0000000000000.
- U-type, XLEN=64, inst 0x800000B7, op 011 -> 0xFFFFFFFF80000000. CSR zimm, inst 0x000FD073, op 111 -> 0x1F.
- Backpressure:
  - Stream 4 back-to-back entries with tags 1..4; hold ready_i=0 for 3 cycles.
  - Expect ready_o to drop the cycle after the skid fills, and valid_o to hold tag 1 stable.
  - Release ready_i -> tags 1,2,3,4 emerge in order, none lost.
- Flush with output and skid both full, and valid_i=1 in the same cycle -> next cycle valid_o=0, ready_o=1, and the same-cycle input does not appear.
- Assert rst_i mid-stream with the skid full -> next cycle valid_o=0, ready_o=1, immgen_o=0, tag_o=0. Resume streaming -> correct results after 1 cycle.
